imem_arb: RTL and testbench
===========================

IMEM_ARB -- requirements
Module: imem_arb

Interface
REQ-001 Parameter STARVE_MAX, default 4: consecutive debug denials after which debug SHALL be forced to win.
REQ-002 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port f_req  input  1  fetch requester read request.
REQ-005 Port f_addr  input  16  fetch word address.
REQ-006 Port f_gnt  output  1  fetch granted this cycle (combinational).
REQ-007 Port f_rvalid  output  1  fetch read data valid (registered).
REQ-008 Port f_rdata  output  16  fetch read data (registered).
REQ-009 Port d_req, d_addr[15:0], d_gnt, d_rvalid, d_rdata[15:0] SHALL mirror REQ-004..008 for the debug/loader requester.
REQ-010 Port dbg_halt  input  1  when high, fetch SHALL never be granted.
REQ-011 Port im_rd_en  output  1  instruction-memory read enable (combinational).
REQ-012 Port im_addr  output  16  instruction-memory address (combinational).
REQ-013 Port im_instr  input  16  instruction-memory data; the memory captures address on falling clk edge, so data is valid before the next rising edge.
REQ-014 Port err  output  1  registered; pulses with rvalid when granted address has addr[15:14] != 0.

Function
REQ-015 At most one of f_gnt/d_gnt SHALL be high in any cycle; im_rd_en SHALL equal f_gnt | d_gnt.
REQ-016 im_addr SHALL carry the winner's address; when no grant, im_addr SHALL be 16'h0000.
REQ-017 Priority: fetch wins when f_req & d_req, unless dbg_halt=1 or starve_cnt == STARVE_MAX, in which case debug wins.
REQ-018 A lone request SHALL be granted the same cycle (except fetch under dbg_halt).
REQ-019 starve_cnt (width clog2(STARVE_MAX+1)) SHALL increment when d_req=1 and d_gnt=0, clear when d_gnt=1 or d_req=0, and never exceed STARVE_MAX.
REQ-020 Latency: grant in cycle N SHALL produce winner's rvalid=1 for exactly one cycle in N+1, with rdata = im_instr sampled at the rising edge ending N.
REQ-021 Non-winner rvalid SHALL be 0; each rdata SHALL hold its last value until that requester's next rvalid.
REQ-022 Out-of-range address (addr[15:14] != 0): read still issued; err=1 in the rvalid cycle; rdata = memory return (memory aliases on addr[13:0]).
REQ-023 Back-to-back grants SHALL be sustained: one read per cycle, no bubbles.
REQ-024 A requester's req deasserting has no effect on an already-issued read; rvalid still returns next cycle.
REQ-025 dbg_halt asserting while a fetch read is in flight SHALL NOT cancel that read's rvalid.

Reset
REQ-026 While rst_n=0 at a rising edge: f_rvalid, d_rvalid, err, starve_cnt SHALL clear to 0; f_rdata, d_rdata SHALL clear to 16'h0000.
REQ-027 While rst_n=0, f_gnt, d_gnt, im_rd_en SHALL be 0 and im_addr 16'h0000.
REQ-028 A read granted in the cycle before reset assertion SHALL produce no rvalid; first post-reset cycle SHALL show rvalid=0.

Structure
REQ-029 Shared package imem_pkg SHALL hold IM_ADDR_W=16, IM_IDX_W=14, IM_DATA_W=16, STARVE_MAX default, and requester-ID enum {REQ_FETCH=0, REQ_DBG=1}.
REQ-030 Starvation counter SHALL be a sub-module imem_arb_starve (inputs d_req, d_gnt; output at_max).
REQ-031 Winner ID SHALL be registered one cycle to route im_instr to the correct rdata.

Verification
REQ-032 Fetch-only, f_addr=0x0000..0x0003 over 4 cycles -> f_rvalid 4 consecutive cycles starting cycle 2, f_rdata = mem[0..3], d_rvalid=0.
REQ-033 f_req, d_req held high, STARVE_MAX=4 -> pattern F,F,F,F,D repeating; d_gnt every 5th cycle; starve_cnt never >4.
REQ-034 dbg_halt=1, f_req=d_req=1, d_addr=0x0010 -> d_gnt every cycle, f_gnt=0, d_rdata=mem[0x10].
REQ-035 d_addr=0x4005 granted -> d_rvalid=1, err=1, d_rdata=mem[0x0005] next cycle.
REQ-036 Fetch granted at cycle N, rst_n=0 in N+1 -> f_rvalid=0, f_rdata=0x0000, all grants 0; after release, first fetch returns normally.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory arbiter slice.
package imem_pkg;

    localparam int IM_ADDR_W      = 16;
    localparam int IM_IDX_W       = 14;
    localparam int IM_DATA_W      = 16;
    localparam int STARVE_MAX_DFLT = 4;

    typedef enum logic {
        REQ_FETCH = 1'b0,
        REQ_DBG   = 1'b1
    } req_id_e;

    // Read issued last cycle, carried to the return stage.
    typedef struct packed {
        logic    vld;
        req_id_e id;
        logic    oor;
    } rd_ret_t;

    // Memory only decodes the low IM_IDX_W bits; anything above is out of range.
    function automatic logic is_oor(input logic [IM_ADDR_W-1:0] addr);
        return addr[IM_ADDR_W-1:IM_IDX_W] != '0;
    endfunction

endpackage

// File: rtl/imem_arb_starve.sv
// Counts consecutive debug denials; at_max forces the next debug request to win.
module imem_arb_starve
    import imem_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DFLT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_req,
    input  logic d_gnt,
    output logic at_max
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt;

    assign at_max = (starve_cnt == CNT_W'(STARVE_MAX));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (d_req && !d_gnt) begin
            if (!at_max) starve_cnt <= starve_cnt + CNT_W'(1);
        end else begin
            starve_cnt <= '0;
        end
    end

endmodule

// File: rtl/imem_arb.sv
// Two-requester instruction-memory arbiter: fetch has priority, debug wins
// under dbg_halt or after STARVE_MAX consecutive denials. One-cycle read return.
module imem_arb
    import imem_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DFLT
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic                 f_req,
    input  logic [IM_ADDR_W-1:0] f_addr,
    output logic                 f_gnt,
    output logic                 f_rvalid,
    output logic [IM_DATA_W-1:0] f_rdata,

    input  logic                 d_req,
    input  logic [IM_ADDR_W-1:0] d_addr,
    output logic                 d_gnt,
    output logic                 d_rvalid,
    output logic [IM_DATA_W-1:0] d_rdata,

    input  logic                 dbg_halt,

    output logic                 im_rd_en,
    output logic [IM_ADDR_W-1:0] im_addr,
    input  logic [IM_DATA_W-1:0] im_instr,

    output logic                 err
);

    logic                 at_max;
    logic                 d_win;
    rd_ret_t              rd_q;
    logic [IM_DATA_W-1:0] f_rdata_q;
    logic [IM_DATA_W-1:0] d_rdata_q;

    imem_arb_starve #(.STARVE_MAX(STARVE_MAX)) u_starve (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_req  (d_req),
        .d_gnt  (d_gnt),
        .at_max (at_max)
    );

    assign d_win    = d_req && (!f_req || dbg_halt || at_max);
    assign d_gnt    = rst_n && d_win;
    assign f_gnt    = rst_n && f_req && !dbg_halt && !d_win;
    assign im_rd_en = f_gnt || d_gnt;

    always_comb begin
        im_addr = '0;
        if (f_gnt)      im_addr = f_addr;
        else if (d_gnt) im_addr = d_addr;
    end

    // Memory data arrives before the edge ending the grant cycle, so capture
    // straight into the winner's holding register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_q      <= '0;
            f_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            rd_q.vld <= im_rd_en;
            rd_q.id  <= d_gnt ? REQ_DBG : REQ_FETCH;
            rd_q.oor <= im_rd_en && is_oor(im_addr);
            if (f_gnt) f_rdata_q <= im_instr;
            if (d_gnt) d_rdata_q <= im_instr;
        end
    end

    // Returns are masked while reset is held so a read issued just before
    // reset never surfaces.
    assign f_rvalid = rst_n && rd_q.vld && (rd_q.id == REQ_FETCH);
    assign d_rvalid = rst_n && rd_q.vld && (rd_q.id == REQ_DBG);
    assign err      = rst_n && rd_q.oor;
    assign f_rdata  = rst_n ? f_rdata_q : '0;
    assign d_rdata  = rst_n ? d_rdata_q : '0;

endmodule

// File: tb/tb_imem_arb.sv
// Self-checking bench for imem_arb against a cycle-level behavioural model.
module tb_imem_arb;

    localparam int SMAX = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        f_req = 1'b0, d_req = 1'b0, dbg_halt = 1'b0;
    logic [15:0] f_addr = '0, d_addr = '0;
    logic        f_gnt, d_gnt, f_rvalid, d_rvalid, im_rd_en, err;
    logic [15:0] f_rdata, d_rdata, im_addr;
    logic [15:0] im_instr = '0;

    logic [15:0] mem [0:16383];

    int n_cmp = 0;
    int n_bad = 0;

    // model state
    logic        m_fwin, m_dwin;
    logic [15:0] m_addr;
    int          m_starve;
    logic        s_fv, s_dv, s_err;
    logic [15:0] s_frd, s_drd;
    logic [18:0] e_comb;
    logic [34:0] e_reg;

    imem_arb #(.STARVE_MAX(SMAX)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .f_req    (f_req),
        .f_addr   (f_addr),
        .f_gnt    (f_gnt),
        .f_rvalid (f_rvalid),
        .f_rdata  (f_rdata),
        .d_req    (d_req),
        .d_addr   (d_addr),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .dbg_halt (dbg_halt),
        .im_rd_en (im_rd_en),
        .im_addr  (im_addr),
        .im_instr (im_instr),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Memory latches the address on the falling edge.
    always @(negedge clk) im_instr <= mem[im_addr[13:0]];

    // Apply one cycle of inputs and derive the expected outputs for that cycle.
    task automatic drive(input logic rst, input logic fr, input logic [15:0] fa,
                         input logic dr, input logic [15:0] da, input logic hl);
        rst_n = rst; f_req = fr; f_addr = fa; d_req = dr; d_addr = da; dbg_halt = hl;
        m_dwin = rst && dr && (!fr || hl || m_starve >= SMAX);
        m_fwin = rst && fr && !hl && !m_dwin;
        m_addr = m_fwin ? fa : (m_dwin ? da : 16'h0000);
        e_comb = {m_fwin, m_dwin, m_fwin | m_dwin, m_addr};
        e_reg  = rst ? {s_fv, s_dv, s_err, s_frd, s_drd} : 35'd0;
        #1;
    endtask

    // Commit the model across the rising edge.
    task automatic advance();
        if (!rst_n) begin
            {s_fv, s_dv, s_err} = 3'b000;
            s_frd = '0; s_drd = '0; m_starve = 0;
        end else begin
            s_fv  = m_fwin;
            s_dv  = m_dwin;
            s_err = (m_fwin || m_dwin) && (m_addr[15:14] != 2'b00);
            if (m_fwin) s_frd = mem[m_addr[13:0]];
            if (m_dwin) s_drd = mem[m_addr[13:0]];
            m_starve = (d_req && !m_dwin) ? ((m_starve < SMAX) ? m_starve + 1 : SMAX) : 0;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 16'h0001, 1'b1, 16'h0002, 1'b0);
            n_cmp++;
            if ({f_gnt, d_gnt, im_rd_en, im_addr} !== 19'd0) begin
                n_bad++; $display("FAIL reset_comb: got %h want 0", {f_gnt, d_gnt, im_rd_en, im_addr});
            end
            n_cmp++;
            if ({f_rvalid, d_rvalid, err, f_rdata, d_rdata} !== 35'd0) begin
                n_bad++; $display("FAIL reset_regs: got %h want 0", {f_rvalid, d_rvalid, err, f_rdata, d_rdata});
            end
            advance();
        end
    endtask

    task automatic test_fetch_seq();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, i < 4, 16'(i), 1'b0, 16'h0, 1'b0);
            n_cmp++;
            if ({f_gnt, d_gnt, im_rd_en, im_addr} !== e_comb) begin
                n_bad++; $display("FAIL fseq_comb[%0d]: got %h want %h", i, {f_gnt, d_gnt, im_rd_en, im_addr}, e_comb);
            end
            if (i >= 1) begin
                n_cmp++;
                if ({f_rvalid, d_rvalid, f_rdata} !== {2'b10, mem[i-1]}) begin
                    n_bad++; $display("FAIL fseq_ret[%0d]: got %b%b/%h want 10/%h", i, f_rvalid, d_rvalid, f_rdata, mem[i-1]);
                end
            end
            advance();
        end
        drive(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
        n_cmp++;
        if ({f_rvalid, f_rdata} !== {1'b0, mem[3]}) begin
            n_bad++; $display("FAIL fseq_hold: got %b/%h want 0/%h", f_rvalid, f_rdata, mem[3]);
        end
        advance();
    endtask

    task automatic test_starve();
        drive(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
        advance();
        for (int i = 0; i < 15; i++) begin
            drive(1'b1, 1'b1, 16'h0100 + 16'(i), 1'b1, 16'h0200 + 16'(i), 1'b0);
            n_cmp++;
            if ({f_gnt, d_gnt} !== ((i % 5 == 4) ? 2'b01 : 2'b10)) begin
                n_bad++; $display("FAIL starve_pat[%0d]: got f%b d%b", i, f_gnt, d_gnt);
            end
            n_cmp++;
            if ({f_rvalid, d_rvalid, err, f_rdata, d_rdata} !== e_reg) begin
                n_bad++; $display("FAIL starve_regs[%0d]: got %h want %h", i, {f_rvalid, d_rvalid, err, f_rdata, d_rdata}, e_reg);
            end
            advance();
        end
    endtask

    task automatic test_halt();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1, 16'h0003, 1'b1, 16'h0010, 1'b1);
            n_cmp++;
            if ({f_gnt, d_gnt, im_addr} !== {2'b01, 16'h0010}) begin
                n_bad++; $display("FAIL halt_gnt[%0d]: got f%b d%b a%h", i, f_gnt, d_gnt, im_addr);
            end
            if (i >= 1) begin
                n_cmp++;
                if ({f_rvalid, d_rvalid, d_rdata} !== {2'b01, mem[16]}) begin
                    n_bad++; $display("FAIL halt_ret[%0d]: got %b%b/%h want 01/%h", i, f_rvalid, d_rvalid, d_rdata, mem[16]);
                end
            end
            advance();
        end
    endtask

    task automatic test_err();
        drive(1'b1, 1'b0, 16'h0, 1'b1, 16'h4005, 1'b0);
        n_cmp++;
        if ({d_gnt, im_rd_en, im_addr} !== {2'b11, 16'h4005}) begin
            n_bad++; $display("FAIL err_issue: got %b%b/%h", d_gnt, im_rd_en, im_addr);
        end
        advance();
        drive(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
        n_cmp++;
        if ({d_rvalid, err, d_rdata} !== {2'b11, mem[5]}) begin
            n_bad++; $display("FAIL err_ret: got %b%b/%h want 11/%h", d_rvalid, err, d_rdata, mem[5]);
        end
        advance();
        drive(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
        n_cmp++;
        if ({d_rvalid, err} !== 2'b00) begin
            n_bad++; $display("FAIL err_pulse: got %b%b want 00", d_rvalid, err);
        end
        advance();
    endtask

    task automatic test_reset_inflight();
        drive(1'b1, 1'b1, 16'h0007, 1'b0, 16'h0, 1'b0);
        advance();
        drive(1'b0, 1'b1, 16'h0008, 1'b1, 16'h0009, 1'b0);
        n_cmp++;
        if ({f_rvalid, f_rdata, f_gnt, d_gnt, im_rd_en, im_addr} !== 36'd0) begin
            n_bad++; $display("FAIL rst_inflight: got v%b d%h g%b%b%b a%h", f_rvalid, f_rdata, f_gnt, d_gnt, im_rd_en, im_addr);
        end
        advance();
        drive(1'b1, 1'b1, 16'h0009, 1'b0, 16'h0, 1'b0);
        n_cmp++;
        if ({f_rvalid, f_rdata, f_gnt} !== {1'b0, 16'h0000, 1'b1}) begin
            n_bad++; $display("FAIL rst_release: got v%b d%h g%b", f_rvalid, f_rdata, f_gnt);
        end
        advance();
        drive(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
        n_cmp++;
        if ({f_rvalid, f_rdata} !== {1'b1, mem[9]}) begin
            n_bad++; $display("FAIL rst_first_fetch: got %b/%h want 1/%h", f_rvalid, f_rdata, mem[9]);
        end
        advance();
    endtask

    task automatic test_random();
        logic [15:0] fa, da;
        for (int i = 0; i < 400; i++) begin
            fa = 16'($urandom); da = 16'($urandom);
            if ($urandom_range(3) != 0) fa[15:14] = 2'b00;
            if ($urandom_range(3) != 0) da[15:14] = 2'b00;
            drive($urandom_range(39) != 0, $urandom_range(3) != 0, fa,
                  $urandom_range(2) != 0, da, $urandom_range(4) == 0);
            n_cmp++;
            if ({f_gnt, d_gnt, im_rd_en, im_addr} !== e_comb) begin
                n_bad++; $display("FAIL rand_comb[%0d]: got %h want %h", i, {f_gnt, d_gnt, im_rd_en, im_addr}, e_comb);
            end
            n_cmp++;
            if ({f_rvalid, d_rvalid, err, f_rdata, d_rdata} !== e_reg) begin
                n_bad++; $display("FAIL rand_regs[%0d]: got %h want %h", i, {f_rvalid, d_rvalid, err, f_rdata, d_rdata}, e_reg);
            end
            advance();
        end
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 16'($urandom);
        m_starve = 0; m_fwin = 0; m_dwin = 0; m_addr = '0;
        {s_fv, s_dv, s_err} = 3'b000; s_frd = '0; s_drd = '0;
        @(posedge clk); #1;
        test_reset();
        test_fetch_seq();
        test_starve();
        test_halt();
        test_err();
        test_reset_inflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
